// File: rtl/mhsa_host_dma.sv
// Host-side sequencer for mhsa_acc_wrapper: streams the input tile into SRAM, runs the
// accelerator, then reads the result region back out through a 2-entry FIFO.
module mhsa_host_dma #(
  parameter int IN_WORDS  = 512,
  parameter int OUT_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_go,
  input  logic [31:0] cfg_input_base,
  input  logic [31:0] cfg_output_base,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [31:0] run_cycles,
  output logic        acc_start,
  input  logic        acc_done,
  output logic [31:0] acc_input_base,
  output logic [31:0] acc_output_base,
  output logic        soc_write_en,
  output logic [63:0] soc_data_in,
  output logic [31:0] soc_addr,
  input  logic [63:0] soc_data_out
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  localparam logic [31:0] IN_LAST  = 32'(IN_WORDS - 1);
  localparam logic [31:0] OUT_LAST = 32'(OUT_WORDS - 1);
  localparam logic [31:0] OUT_N    = 32'(OUT_WORDS);

  state_t          state;
  logic [31:0]     in_base, out_base;
  logic [31:0]     wr_idx, rd_idx, pop_idx;
  logic [1:0][63:0] fifo_mem;
  logic            fifo_wp, fifo_rp;
  logic [1:0]      fifo_cnt;
  logic            rd_pend;     // read issued last cycle, its data is on soc_data_out now
  logic            load_hs, rd_issue, pop, pop_fifo, push;

  assign acc_input_base  = in_base;
  assign acc_output_base = out_base;

  assign load_hs  = in_ready & in_valid;
  // Credit check counts the in-flight read so the FIFO can never overflow.
  assign rd_issue = (state == DRAIN) && (rd_idx != OUT_N) &&
                    ((fifo_cnt + {1'b0, rd_pend}) < 2'd2);

  // The in-flight word bypasses the FIFO when it is empty, giving one word per cycle.
  assign out_valid = (fifo_cnt != 2'd0) | rd_pend;
  assign out_data  = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rp] :
                     rd_pend            ? soc_data_out      : 64'd0;
  assign out_last  = out_valid && (pop_idx == OUT_LAST);
  assign pop       = out_valid & out_ready;
  assign pop_fifo  = pop & (fifo_cnt != 2'd0);
  assign push      = rd_pend & ~(pop & (fifo_cnt == 2'd0));

  assign soc_write_en = load_hs;
  assign soc_data_in  = load_hs ? in_data : 64'd0;
  assign soc_addr     = load_hs  ? in_base + wr_idx  :
                        rd_issue ? out_base + rd_idx : 32'd0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= soc_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_base    <= '0;
      out_base   <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      pop_idx    <= '0;
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_cnt   <= '0;
      rd_pend    <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      acc_start  <= 1'b0;
      run_cycles <= '0;
    end else begin
      rd_pend  <= rd_issue;
      if (push)     fifo_wp <= ~fifo_wp;
      if (pop_fifo) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop_fifo};
      if (rd_issue) rd_idx  <= rd_idx + 32'd1;
      if (pop)      pop_idx <= pop_idx + 32'd1;

      case (state)
        IDLE: if (cfg_go) begin
          in_base  <= cfg_input_base;
          out_base <= cfg_output_base;
          wr_idx   <= '0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          state    <= LOAD;
        end
        LOAD: if (load_hs) begin
          wr_idx <= wr_idx + 32'd1;
          if (wr_idx == IN_LAST) begin
            in_ready   <= 1'b0;
            acc_start  <= 1'b1;
            run_cycles <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (run_cycles != 32'hFFFF_FFFF) run_cycles <= run_cycles + 32'd1;
          if (acc_done) begin
            acc_start <= 1'b0;
            rd_idx    <= '0;
            pop_idx   <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: if (pop && (pop_idx == OUT_LAST)) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
